// File: rtl/typewriter_out_if.sv
// ============================================================================
// Module   : typewriter_out_if
// Purpose  : Slow-out typewriter sink. It paces accepted characters to the
//            mechanical character time and buffers them for the host in a FIFO.
// Option   : define TW_CODE_MAP_EN to store ASCII instead of raw {OS,OB5..OB1}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module typewriter_out_if #(
  parameter int DEPTH     = 4,
  parameter int CHAR_TIME = 1000
) (
  input  logic                     CLOCK,
  input  logic                     rst,
  input  logic                     OB1,
  input  logic                     OB2,
  input  logic                     OB3,
  input  logic                     OB4,
  input  logic                     OB5,
  input  logic                     OS,
  input  logic                     PRINT_STB,
  output logic                     TW_BUSY,
  output logic                     TW_OVERFLOW,
  input  logic                     ovf_clr,
  output logic                     char_valid,
  output logic [7:0]               char_data,
  input  logic                     char_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CHAR_TIME);
  localparam logic [CW-1:0] c_FULL      = CW'(DEPTH);
  localparam logic [TW-1:0] c_TIMER_LD  = TW'(CHAR_TIME - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic            w_accept;
  logic            w_pop;
  logic [5:0]      w_raw;
  logic [7:0]      w_char;

  function automatic logic [7:0] f_encode(input logic [5:0] c);
`ifdef TW_CODE_MAP_EN
    logic [7:0] v;
    v = 8'h3F;
    if (c[4]) begin
      if (c[3:0] <= 4'd9) v = 8'h30 + {4'b0000, c[3:0]};
      else                v = 8'h75 + {4'b0000, c[3:0]} - 8'd10;
    end else if (!c[3]) begin
      case (c[2:0])
        3'd0:    v = 8'h20;
        3'd1:    v = c[5] ? 8'h2D : 8'h20;
        3'd2:    v = 8'h0D;
        3'd3:    v = 8'h09;
        3'd4:    v = 8'h00;
        3'd5:    v = 8'h12;
        3'd6:    v = 8'h2E;
        default: v = 8'h00;
      endcase
    end
    return v;
`else
    return {2'b00, c};
`endif
  endfunction

  // Busy depends on registered state only, so the I/O side sees a clean level.
  assign TW_BUSY    = (r_state == S_HOLD) | (r_count == c_FULL);
  assign w_accept   = PRINT_STB & ~TW_BUSY;
  assign char_valid = (r_count != '0);
  assign w_pop      = char_valid & char_ready;
  assign w_raw      = {OS, OB5, OB4, OB3, OB2, OB1};
  assign w_char     = f_encode(w_raw);
  assign char_data  = r_mem[r_rd];
  assign fifo_count = r_count;
  assign TW_OVERFLOW = r_ovf;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_HOLD;
            r_timer <= c_TIMER_LD;
          end
        end
        S_HOLD: begin
          if (r_timer == '0) r_state <= S_IDLE;
          else               r_timer <= r_timer - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr] <= w_char;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // A new drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge CLOCK) begin
    if (rst)                         r_ovf <= 1'b0;
    else if (PRINT_STB && TW_BUSY)   r_ovf <= 1'b1;
    else if (ovf_clr)                r_ovf <= 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_typewriter_out_if.sv
// Directed bench for typewriter_out_if (DEPTH=4, CHAR_TIME=8); honours TW_CODE_MAP_EN.
`default_nettype none

module tb_typewriter_out_if;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b1;
  logic       OB1 = 0, OB2 = 0, OB3 = 0, OB4 = 0, OB5 = 0, OS = 0;
  logic       PRINT_STB = 0;
  logic       TW_BUSY, TW_OVERFLOW;
  logic       ovf_clr = 0;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready = 0;
  logic [2:0] fifo_count;

  int vectors = 0;
  int errors  = 0;

  typewriter_out_if #(.DEPTH(4), .CHAR_TIME(8)) dut (
    .CLOCK(CLOCK), .rst(rst),
    .OB1(OB1), .OB2(OB2), .OB3(OB3), .OB4(OB4), .OB5(OB5), .OS(OS),
    .PRINT_STB(PRINT_STB), .TW_BUSY(TW_BUSY), .TW_OVERFLOW(TW_OVERFLOW),
    .ovf_clr(ovf_clr), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .fifo_count(fifo_count)
  );

  always #5 CLOCK = ~CLOCK;

  // Hand-written expected output per character code used below.
  function automatic logic [7:0] exp_of(input logic [5:0] c);
`ifdef TW_CODE_MAP_EN
    case (c)
      6'h15: return 8'h35;  // '5'
      6'h03: return 8'h09;
      6'h11: return 8'h31;  // '1'
      6'h22: return 8'h0D;
      6'h3B: return 8'h76;  // 'v'
      6'h26: return 8'h2E;  // '.'
      6'h21: return 8'h2D;  // '-'
      6'h01: return 8'h20;
      6'h0C: return 8'h3F;  // '?'
      6'h19: return 8'h39;  // '9'
      6'h1F: return 8'h7A;  // 'z'
      6'h04: return 8'h00;
      6'h25: return 8'h12;
      6'h10: return 8'h30;  // '0'
      6'h1A: return 8'h75;  // 'u'
      default: return 8'hFF;
    endcase
`else
    return {2'b00, c};
`endif
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_char(input logic [5:0] c);
    {OS, OB5, OB4, OB3, OB2, OB1} = c;
  endtask

  task automatic strobe(input logic [5:0] c);
    set_char(c);
    PRINT_STB = 1'b1;
    tick();
    PRINT_STB = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (TW_BUSY && n < 50) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, TW_BUSY}, 32'd0);
  endtask

  logic [5:0] seq [10] = '{6'h21, 6'h01, 6'h0C, 6'h19, 6'h1F,
                           6'h04, 6'h25, 6'h10, 6'h1A, 6'h15};
  logic [5:0] full_set [4] = '{6'h11, 6'h22, 6'h3B, 6'h26};

  initial begin
    int n;

    // Reset
    tick(); tick();
    chk("rst_busy",  {31'd0, TW_BUSY},     0);
    chk("rst_ovf",   {31'd0, TW_OVERFLOW}, 0);
    chk("rst_valid", {31'd0, char_valid},  0);
    chk("rst_data",  {24'd0, char_data},   0);
    chk("rst_count", {29'd0, fifo_count},  0);
    rst = 1'b0;
    tick();

    // Single char, busy exactly CHAR_TIME cycles
    strobe(6'h15);
    chk("single_valid", {31'd0, char_valid}, 1);
    chk("single_data",  {24'd0, char_data},  {24'd0, exp_of(6'h15)});
    n = 0;
    while (TW_BUSY && n < 50) begin
      n++;
      tick();
    end
    chk("single_busy_len", n, 8);
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    chk("single_popped", {29'd0, fifo_count}, 0);
    chk("single_novalid", {31'd0, char_valid}, 0);

    // Busy drop and overflow flag
    strobe(6'h03);
    tick(); tick();
    strobe(6'h1F);
    chk("drop_count", {29'd0, fifo_count}, 1);
    chk("drop_ovf",   {31'd0, TW_OVERFLOW}, 1);
    PRINT_STB = 1'b1; ovf_clr = 1'b1;
    tick();
    PRINT_STB = 1'b0;
    chk("ovf_set_wins", {31'd0, TW_OVERFLOW}, 1);
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, TW_OVERFLOW}, 0);
    wait_idle("drop_idle");
    chk("drop_head", {24'd0, char_data}, {24'd0, exp_of(6'h03)});
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;

    // Full FIFO
    for (int i = 0; i < 4; i++) begin
      wait_idle("full_idle");
      strobe(full_set[i]);
    end
    chk("full_count", {29'd0, fifo_count}, 4);
    for (int i = 0; i < 10; i++) tick();
    chk("full_busy", {31'd0, TW_BUSY}, 1);
    chk("full_head0", {24'd0, char_data}, {24'd0, exp_of(full_set[0])});
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    chk("full_busy_fall", {31'd0, TW_BUSY}, 0);
    chk("full_count3", {29'd0, fifo_count}, 3);
    for (int i = 1; i < 4; i++) begin
      chk("full_order", {24'd0, char_data}, {24'd0, exp_of(full_set[i])});
      char_ready = 1'b1;
      tick();
      char_ready = 1'b0;
    end
    chk("full_empty", {29'd0, fifo_count}, 0);

    // Simultaneous push/pop across pointer wrap
    strobe(6'h15);
    for (int i = 0; i < 10; i++) begin
      wait_idle("pp_idle");
      set_char(seq[i]);
      PRINT_STB = 1'b1; char_ready = 1'b1;
      tick();
      PRINT_STB = 1'b0; char_ready = 1'b0;
      chk("pp_count", {29'd0, fifo_count}, 1);
      chk("pp_head",  {24'd0, char_data}, {24'd0, exp_of(seq[i])});
    end
    wait_idle("pp_final_idle");
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    chk("pp_empty", {29'd0, fifo_count}, 0);

    // Reset mid-HOLD with two entries
    strobe(6'h11);
    wait_idle("rh_idle");
    strobe(6'h22);
    tick(); tick(); tick(); tick();
    chk("rh_pre_count", {29'd0, fifo_count}, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rh_busy",  {31'd0, TW_BUSY},    0);
    chk("rh_valid", {31'd0, char_valid}, 0);
    chk("rh_count", {29'd0, fifo_count}, 0);
    strobe(6'h26);
    chk("rh_accept_count", {29'd0, fifo_count}, 1);
    chk("rh_accept_busy",  {31'd0, TW_BUSY},    1);
    chk("rh_accept_data",  {24'd0, char_data},  {24'd0, exp_of(6'h26)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
